// File: rtl/mips32_mem_responder.sv
// -----------------------------------------------------------------------------
// mips32_mem_responder
//
// Word-addressed 32-bit memory that serves the MIPS32 core's instruction-fetch
// port and data (LW/SW) port through a req/ack handshake. The two ports are
// arbitrated round-robin, one access is in flight at a time, and read data is
// returned from registered outputs with a fixed latency.
//
// Configuration macro: MEM_WAIT_EN
//   defined   -> WAIT state and wait counter are built; each access stalls
//                WAIT_CYCLES extra cycles (latency 1 + WAIT_CYCLES).
//   undefined -> no WAIT state or counter; every access has latency 1.
//
// Parameters:
//   AW          word-address width (memory holds 2**AW words)
//   WAIT_CYCLES extra wait states per access (only with MEM_WAIT_EN)
//
// Ports:
//   clk1     sole clock, rising edge
//   rst      asynchronous active-high reset
//   i_req    fetch request, held until i_ack
//   i_addr   fetch word address
//   i_ack    one-cycle fetch completion pulse
//   i_rdata  fetched word, valid while i_ack=1, held otherwise
//   d_req    data request, held until d_ack
//   d_we     1 = store, 0 = load
//   d_addr   data word address
//   d_wdata  store data
//   d_ack    one-cycle data completion pulse
//   d_rdata  load data, valid while d_ack=1 (0 on store acks), held otherwise
//   busy     transaction in flight, including its ack cycle
// -----------------------------------------------------------------------------
module mips32_mem_responder #(
    parameter int AW          = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic          clk1,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [31:0]   i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_ack,
    output logic [31:0]   d_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    typedef enum logic {PORT_I, PORT_D} port_t;

    if (WAIT_CYCLES < 0) begin : g_param_check
        $error("WAIT_CYCLES must be non-negative");
    end

    state_t        state_q, state_d;
    port_t         port_q, port_d;
    port_t         last_grant_q, last_grant_d;
    port_t         grant;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          i_ack_q, i_ack_d;
    logic          d_ack_q, d_ack_d;
    logic [31:0]   i_rdata_q, i_rdata_d;
    logic [31:0]   d_rdata_q, d_rdata_d;
    logic          busy_q, busy_d;
    logic [31:0]   mem_rd;

`ifdef MEM_WAIT_EN
    localparam int CW = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    logic [31:0] mem [0:(2**AW)-1];

    assign mem_rd = mem[addr_q];

    // NOTE: the array has no reset branch so it maps onto RAM; contents
    // survive rst. A reset-time abort is still safe because state_q is
    // forced out of S_RESP asynchronously, which kills the write enable.
    always_ff @(posedge clk1) begin
        if (state_q == S_RESP && port_q == PORT_D && we_q) begin
            mem[addr_q] <= wdata_q;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        port_d       = port_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        i_ack_d      = 1'b0;
        d_ack_d      = 1'b0;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        grant        = PORT_I;
`ifdef MEM_WAIT_EN
        cnt_d        = cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                // An ack still showing means the previous transaction just
                // finished; the port's req may not have dropped yet, so skip
                // arbitration for this cycle.
                if (!i_ack_q && !d_ack_q && (i_req || d_req)) begin
                    if (i_req && d_req) begin
                        grant = (last_grant_q == PORT_I) ? PORT_D : PORT_I;
                    end else if (d_req) begin
                        grant = PORT_D;
                    end else begin
                        grant = PORT_I;
                    end
                    port_d  = grant;
                    addr_d  = (grant == PORT_D) ? d_addr : i_addr;
                    we_d    = (grant == PORT_D) && d_we;
                    wdata_d = d_wdata;
`ifdef MEM_WAIT_EN
                    cnt_d   = CW'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
`else
                    state_d = S_RESP;
`endif
                end
            end
`ifdef MEM_WAIT_EN
            S_WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= CW'(1)) begin
                    state_d = S_RESP;
                end
            end
`endif
            S_RESP: begin
                state_d      = S_IDLE;
                last_grant_d = port_q;
                if (port_q == PORT_I) begin
                    i_ack_d   = 1'b1;
                    i_rdata_d = mem_rd;
                end else begin
                    d_ack_d   = 1'b1;
                    d_rdata_d = we_q ? 32'h0 : mem_rd;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // busy covers the ack cycle as well as the access itself.
        busy_d = (state_d != S_IDLE) || i_ack_d || d_ack_d;
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            port_q       <= PORT_I;
            last_grant_q <= PORT_I;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            busy_q       <= 1'b0;
`ifdef MEM_WAIT_EN
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            port_q       <= port_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            i_ack_q      <= i_ack_d;
            d_ack_q      <= d_ack_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            busy_q       <= busy_d;
`ifdef MEM_WAIT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign i_ack   = i_ack_q;
    assign d_ack   = d_ack_q;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign busy    = busy_q;

endmodule
